axil_advanced_register_cu: RTL and testbench

AXIL_ADVANCED_REGISTER_CU -- requirements
Module: axil_advanced_register_cu

---
 rtl/axil_advanced_register_cu_if.sv | 30 +++
 rtl/axil_advanced_register_cu.sv | 183 ++++++++++++++++++
 tb/tb_axil_advanced_register_cu.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_advanced_register_cu_if.sv
// rtl/axil_advanced_register_cu_if.sv - AXI4-Lite channel bundle with slave and master views
interface axi_lite;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_advanced_register_cu.sv
// rtl/axil_advanced_register_cu.sv - AXI4-Lite register map with RO sources, byte strobes and write triggers
module axil_advanced_register_cu #(
  parameter int                             N_REGISTERS           = 8,
  parameter logic [N_REGISTERS-1:0]         RO_MASK               = '0,
  parameter logic [N_REGISTERS-1:0]         TRIGGER_MASK          = '0,
  parameter logic [N_REGISTERS-1:0][31:0]   INITIAL_OUTPUT_VALUES = '0,
  parameter logic [31:0]                    ADDRESS_MASK          = 32'hFFFF_FFFF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_REGISTERS-1:0][31:0]     input_registers,
  output logic [N_REGISTERS-1:0][31:0]     output_registers,
  output logic [N_REGISTERS-1:0]           trigger_out,
  axi_lite.slave                           axil
);

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;

  w_state_t                         r_w_state;
  logic                             r_awready;
  logic                             r_wready;
  logic [31:0]                      r_awaddr;
  logic [31:0]                      r_wdata;
  logic [3:0]                       r_wstrb;
  logic                             r_bvalid;
  logic [1:0]                       r_bresp;
  logic [N_REGISTERS-1:0][31:0]     r_out_regs;
  logic [N_REGISTERS-1:0]           r_trigger;

  r_state_t                         r_r_state;
  logic                             r_arready;
  logic [31:0]                      r_araddr;
  logic                             r_rvalid;
  logic [31:0]                      r_rdata;
  logic [1:0]                       r_rresp;

  logic                             w_aw_hs;
  logic                             w_w_hs;
  logic                             w_ar_hs;
  logic [31:0]                      w_widx;
  logic [31:0]                      w_ridx;
  logic [N_REGISTERS-1:0]           w_wsel;
  logic [N_REGISTERS-1:0]           w_rsel;
  logic                             w_w_ok;
  logic                             w_r_in_range;
  logic [31:0]                      w_byte_mask;
  logic [31:0]                      w_rd_val;

  assign w_aw_hs = axil.awvalid && r_awready;
  assign w_w_hs  = axil.wvalid && r_wready;
  assign w_ar_hs = axil.arvalid && r_arready;

  assign w_widx = (r_awaddr & ADDRESS_MASK) >> 2;
  assign w_ridx = (r_araddr & ADDRESS_MASK) >> 2;

  // One-hot slot decode; an all-zero select means the index is out of range.
  always_comb begin
    w_wsel = '0;
    w_rsel = '0;
    for (int i = 0; i < N_REGISTERS; i++) begin
      w_wsel[i] = (w_widx == 32'(i));
      w_rsel[i] = (w_ridx == 32'(i));
    end
  end

  assign w_w_ok       = |(w_wsel & ~RO_MASK);
  assign w_r_in_range = |w_rsel;
  assign w_byte_mask  = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < N_REGISTERS; i++) begin
      if (w_rsel[i]) begin
        w_rd_val = RO_MASK[i] ? input_registers[i] : r_out_regs[i];
      end
    end
  end

  // In W_IDLE a dropped ready flag doubles as the "channel already captured" marker.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_w_state  <= W_IDLE;
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_out_regs <= INITIAL_OUTPUT_VALUES;
      r_trigger  <= '0;
    end else begin
      r_trigger <= '0;
      case (r_w_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr  <= axil.awaddr;
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata  <= axil.wdata;
            r_wstrb  <= axil.wstrb;
            r_wready <= 1'b0;
          end
          if ((w_aw_hs || !r_awready) && (w_w_hs || !r_wready)) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_w_state <= W_EXEC;
          end
        end
        W_EXEC: begin
          for (int i = 0; i < N_REGISTERS; i++) begin
            if (w_wsel[i] && !RO_MASK[i]) begin
              r_out_regs[i] <= (r_out_regs[i] & ~w_byte_mask) | (r_wdata & w_byte_mask);
              r_trigger[i]  <= TRIGGER_MASK[i];
            end
          end
          r_bresp   <= w_w_ok ? 2'b00 : 2'b10;
          r_bvalid  <= 1'b1;
          r_w_state <= W_RESP;
        end
        W_RESP: begin
          if (axil.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_w_state <= W_IDLE;
          end
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_r_state <= R_IDLE;
      r_arready <= 1'b1;
      r_araddr  <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      case (r_r_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_araddr  <= axil.araddr;
            r_arready <= 1'b0;
            r_r_state <= R_FETCH;
          end
        end
        R_FETCH: begin
          r_rdata   <= w_rd_val;
          r_rresp   <= w_r_in_range ? 2'b00 : 2'b10;
          r_rvalid  <= 1'b1;
          r_r_state <= R_RESP;
        end
        R_RESP: begin
          if (axil.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_r_state <= R_IDLE;
          end
        end
        default: r_r_state <= R_IDLE;
      endcase
    end
  end

  assign output_registers = r_out_regs;
  assign trigger_out      = r_trigger;

  assign axil.awready = r_awready;
  assign axil.wready  = r_wready;
  assign axil.bvalid  = r_bvalid;
  assign axil.bresp   = r_bresp;
  assign axil.arready = r_arready;
  assign axil.rvalid  = r_rvalid;
  assign axil.rdata   = r_rdata;
  assign axil.rresp   = r_rresp;

endmodule

// File: tb/tb_axil_advanced_register_cu.sv
// tb/tb_axil_advanced_register_cu.sv - self-checking bench for axil_advanced_register_cu
module tb_axil_advanced_register_cu;
  localparam int              N     = 8;
  localparam logic [7:0]      RO    = 8'h81;
  localparam logic [7:0]      TRIG  = 8'h25;
  localparam logic [31:0]     AMASK = 32'h0000_00FF;
  localparam logic [7:0][31:0] INIT = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                                       32'h3333_0003, 32'h0000_0000, 32'h1111_0001, 32'h0F0F_0000};

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0][31:0] in_regs;
  logic [N-1:0][31:0] out_regs;
  logic [N-1:0]      trig;
  int                cyc = 0;
  int                n_checks = 0;
  int                n_errors = 0;
  logic [31:0]       m_regs [N];

  axi_lite bus ();

  axil_advanced_register_cu #(
    .N_REGISTERS(N), .RO_MASK(RO), .TRIGGER_MASK(TRIG),
    .INITIAL_OUTPUT_VALUES(INIT), .ADDRESS_MASK(AMASK)
  ) dut (
    .clock(clock), .reset(reset), .input_registers(in_regs),
    .output_registers(out_regs), .trigger_out(trig), .axil(bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: slot index is the masked byte address divided by four.
  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = INIT[i];
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, output logic [1:0] resp,
                                      output logic [7:0] exp_trig);
    int unsigned idx;
    idx = (addr & AMASK) / 4;
    exp_trig = '0;
    resp = 2'b10;
    if (idx < 32'(N)) begin
      if (!RO[idx]) begin
        resp = 2'b00;
        for (int k = 0; k < 4; k++)
          if (strb[k]) m_regs[idx][8*k +: 8] = data[8*k +: 8];
        if (TRIG[idx]) exp_trig[idx] = 1'b1;
      end
    end
  endfunction

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int unsigned idx;
    idx = (addr & AMASK) / 4;
    data = '0;
    resp = 2'b10;
    if (idx < 32'(N)) begin
      resp = 2'b00;
      data = RO[idx] ? in_regs[idx] : m_regs[idx];
    end
  endfunction

  function automatic logic [N-1:0][31:0] model_outs();
    logic [N-1:0][31:0] v;
    for (int i = 0; i < N; i++) v[i] = m_regs[i];
    return v;
  endfunction

  task automatic do_write(input string nm, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] exp_resp, input logic [7:0] exp_trig);
    bit stall_ok;
    fork
      begin
        int n;
        n = 0;
        repeat (aw_dly) @(negedge clock);
        bus.awaddr = addr;
        bus.awvalid = 1'b1;
        while (!bus.awready && n < 50) begin @(negedge clock); n++; end
        if (!bus.awready) chk({nm, " aw_timeout"}, 256'(bus.awready), 256'(1));
        else begin @(posedge clock); @(negedge clock); end
        bus.awvalid = 1'b0;
      end
      begin
        int n;
        n = 0;
        repeat (w_dly) @(negedge clock);
        bus.wdata = data;
        bus.wstrb = strb;
        bus.wvalid = 1'b1;
        while (!bus.wready && n < 50) begin @(negedge clock); n++; end
        if (!bus.wready) chk({nm, " w_timeout"}, 256'(bus.wready), 256'(1));
        else begin @(posedge clock); @(negedge clock); end
        bus.wvalid = 1'b0;
      end
    join
    bus.bready = (b_dly == 0);
    chk({nm, " exec"}, 256'({bus.bvalid, trig}), 256'(0));
    @(negedge clock);
    chk({nm, " trig"}, 256'(trig), 256'(exp_trig));
    chk({nm, " bvalid"}, 256'(bus.bvalid), 256'(1));
    chk({nm, " bresp"}, 256'(bus.bresp), 256'(exp_resp));
    chk({nm, " regs"}, 256'(out_regs), 256'(model_outs()));
    stall_ok = 1'b1;
    repeat (b_dly) begin
      @(negedge clock);
      stall_ok = stall_ok && bus.bvalid && !bus.awready && !bus.wready && (trig == '0);
    end
    if (b_dly > 0) chk({nm, " b_stall"}, 256'(stall_ok), 256'(1));
    bus.bready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.bready = 1'b0;
    chk({nm, " b_done"}, 256'({bus.bvalid, bus.awready, bus.wready, trig}), 256'({3'b011, 8'h00}));
  endtask

  task automatic do_read(input string nm, input logic [31:0] addr, input int r_dly,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    bit stable;
    logic [31:0] d0;
    n = 0;
    bus.araddr = addr;
    bus.arvalid = 1'b1;
    while (!bus.arready && n < 50) begin @(negedge clock); n++; end
    if (!bus.arready) chk({nm, " ar_timeout"}, 256'(bus.arready), 256'(1));
    else begin @(posedge clock); @(negedge clock); end
    bus.arvalid = 1'b0;
    chk({nm, " fetch"}, 256'({bus.rvalid, bus.arready}), 256'(0));
    @(negedge clock);
    chk({nm, " rvalid"}, 256'(bus.rvalid), 256'(1));
    chk({nm, " rdata"}, 256'(bus.rdata), 256'(exp_data));
    chk({nm, " rresp"}, 256'(bus.rresp), 256'(exp_resp));
    d0 = bus.rdata;
    stable = 1'b1;
    repeat (r_dly) begin
      @(negedge clock);
      stable = stable && bus.rvalid && !bus.arready && (bus.rdata == d0);
    end
    if (r_dly > 0) chk({nm, " r_stall"}, 256'(stable), 256'(1));
    bus.rready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.rready = 1'b0;
    chk({nm, " r_done"}, 256'({bus.rvalid, bus.arready}), 256'(2'b01));
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          rsp_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [7:0]  trig;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [1:0]  mresp;
    logic [7:0]  mtrig;
    logic [31:0] mdata;
    logic [31:0] pre;

    tbl[0]  = '{1'b1, 32'h08,   32'hDEADBEEF, 4'b0101, 0, 0, 0,  2'b00, 32'h0,        8'h04};
    tbl[1]  = '{1'b0, 32'h08,   32'h0,        4'h0,    0, 0, 0,  2'b00, 32'h00AD00EF, 8'h00};
    tbl[2]  = '{1'b1, 32'h08,   32'hA5A5A5A5, 4'hF,    3, 0, 0,  2'b00, 32'h0,        8'h04};
    tbl[3]  = '{1'b0, 32'h08,   32'h0,        4'h0,    0, 0, 2,  2'b00, 32'hA5A5A5A5, 8'h00};
    tbl[4]  = '{1'b1, 32'h00,   32'hFFFFFFFF, 4'hF,    0, 0, 0,  2'b10, 32'h0,        8'h00};
    tbl[5]  = '{1'b0, 32'h00,   32'h0,        4'h0,    0, 0, 0,  2'b00, 32'h12345678, 8'h00};
    tbl[6]  = '{1'b0, 32'h40,   32'h0,        4'h0,    0, 0, 0,  2'b10, 32'h00000000, 8'h00};
    tbl[7]  = '{1'b1, 32'h40,   32'h11223344, 4'hF,    0, 2, 0,  2'b10, 32'h0,        8'h00};
    tbl[8]  = '{1'b0, 32'h1C,   32'h0,        4'h0,    0, 0, 0,  2'b00, 32'hCAFEF00D, 8'h00};
    tbl[9]  = '{1'b1, 32'h0C,   32'h01234567, 4'b1010, 0, 0, 10, 2'b00, 32'h0,        8'h00};
    tbl[10] = '{1'b0, 32'h100C, 32'h0,        4'h0,    0, 0, 0,  2'b00, 32'h01334503, 8'h00};
    tbl[11] = '{1'b0, 32'h0E,   32'h0,        4'h0,    0, 0, 0,  2'b00, 32'h01334503, 8'h00};
    tbl[12] = '{1'b1, 32'h14,   32'h99999999, 4'h0,    1, 0, 0,  2'b00, 32'h0,        8'h20};
    tbl[13] = '{1'b0, 32'h14,   32'h0,        4'h0,    0, 0, 0,  2'b00, 32'h55550005, 8'h00};
    tbl[14] = '{1'b1, 32'h1F,   32'h0,        4'hF,    0, 0, 0,  2'b10, 32'h0,        8'h00};
    tbl[15] = '{1'b0, 32'h04,   32'h0,        4'h0,    0, 0, 0,  2'b00, 32'h11110001, 8'h00};

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int i = 0; i < N; i++) in_regs[i] = $urandom;
    in_regs[0] = 32'h12345678;
    in_regs[7] = 32'hCAFEF00D;
    model_reset();

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("reset readies", 256'({bus.awready, bus.wready, bus.arready}), 256'(3'b111));
    chk("reset valids", 256'({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}), 256'(0));
    chk("reset rdata", 256'(bus.rdata), 256'(0));
    chk("reset regs", 256'(out_regs), 256'(INIT));
    chk("reset trig", 256'(trig), 256'(0));

    for (int v = 0; v < 16; v++) begin
      if (tbl[v].wr) begin
        model_write(tbl[v].addr, tbl[v].data, tbl[v].strb, mresp, mtrig);
        do_write($sformatf("tbl%0d", v), tbl[v].addr, tbl[v].data, tbl[v].strb,
                 tbl[v].aw_dly, tbl[v].w_dly, tbl[v].rsp_dly, tbl[v].resp, tbl[v].trig);
      end else begin
        do_read($sformatf("tbl%0d", v), tbl[v].addr, tbl[v].rsp_dly, tbl[v].rdata, tbl[v].resp);
      end
    end

    // Write response held off while a read of the same slot completes.
    bus.awaddr = 32'h10; bus.wdata = 32'hABCD0123; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    model_write(32'h10, 32'hABCD0123, 4'hF, mresp, mtrig);
    @(negedge clock);
    chk("bp bvalid", 256'(bus.bvalid), 256'(1));
    do_read("bp read", 32'h10, 0, 32'hABCD0123, 2'b00);
    chk("bp held", 256'({bus.bvalid, bus.awready, bus.wready}), 256'(3'b100));
    bus.bready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.bready = 1'b0;
    chk("bp done", 256'({bus.bvalid, bus.awready, bus.wready}), 256'(3'b011));

    // Read fetch on the same edge as a write commit to the same slot.
    bus.awaddr = 32'h10; bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.araddr = 32'h10;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    pre = m_regs[4];
    model_write(32'h10, 32'h0BADF00D, 4'hF, mresp, mtrig);
    chk("col fetch", 256'({bus.bvalid, bus.rvalid}), 256'(0));
    @(negedge clock);
    chk("col rdata", 256'({bus.rvalid, bus.rdata}), 256'({1'b1, pre}));
    chk("col regs", 256'({bus.bvalid, out_regs}), 256'({1'b1, model_outs()}));
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.bready = 1'b0; bus.rready = 1'b0;
    chk("col done", 256'({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}), 256'(5'b00111));

    // Reset landing in W_EXEC and R_FETCH aborts both transactions.
    bus.awaddr = 32'h04; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.araddr = 32'h08;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    chk("rst regs", 256'(out_regs), 256'(INIT));
    chk("rst resp", 256'({bus.bvalid, bus.rvalid, trig, bus.rdata}), 256'(0));
    chk("rst readies", 256'({bus.awready, bus.wready, bus.arready}), 256'(3'b111));
    @(negedge clock);
    chk("rst quiet", 256'({bus.bvalid, bus.rvalid, trig, out_regs}), 256'({2'b00, 8'h00, INIT}));
    do_read("rst read", 32'h04, 0, 32'h11110001, 2'b00);

    for (int t = 0; t < 200; t++) begin
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      addr = $urandom_range(0, 11) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) addr = addr + 32'h0000_3F00;
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      in_regs[0] = $urandom;
      in_regs[7] = $urandom;
      in_regs[3] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        model_write(addr, data, strb, mresp, mtrig);
        do_write($sformatf("rnd%0d wr", t), addr, data, strb, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), mresp, mtrig);
      end else begin
        model_read(addr, mdata, mresp);
        do_read($sformatf("rnd%0d rd", t), addr, $urandom_range(0, 2), mdata, mresp);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
